// File: rtl/video_timing_sequencer.sv
// ----------------------------------------------------------------------------
// video_timing_sequencer
//
// Scanline/frame sequencer for the composite video generator. It keeps the
// horizontal and vertical pixel counters, runs a per-line segment FSM, and
// drives the generator controls (SYNC, BURST, n_PICTURE) and the frame-timing
// strobes (HC, VC, VB). On odd frames with rendering enabled, the last line is
// one pixel short. This keeps the colour-subcarrier phase alternating between
// frames.
//
// Ports:
//   CLK        master clock, all state on the rising edge
//   n_RES      asynchronous active-low reset
//   PCLK_EN    pixel tick; state only advances on enabled edges
//   REN        rendering enabled (gates the odd-frame shortening)
//   H_out      current pixel position (9 bits)
//   V_out      current line (9 bits)
//   SYNC       sync level request (inverted on vertical-sync lines)
//   BURST      colour-burst request
//   n_PICTURE  low while the pixel is visible picture
//   HC         last pixel of the line
//   VC         whole last line of the frame
//   VB         vblank lines V_VB_S..V_TOTAL-2
//   ODD        frame parity, toggles at every frame wrap
//
// Every output is a register. Its next value is decoded from the next counter
// and state values, so it always describes the H_out/V_out of the same cycle.
// ----------------------------------------------------------------------------
module video_timing_sequencer #(
    parameter int H_TOTAL   = 341,
    parameter int H_PIC     = 256,
    parameter int H_SYNC_S  = 277,
    parameter int H_SYNC_E  = 302,
    parameter int H_BURST_S = 306,
    parameter int H_BURST_E = 321,
    parameter int V_TOTAL   = 262,
    parameter int V_PIC     = 240,
    parameter int V_VB_S    = 241,
    parameter int V_VSYNC_S = 244,
    parameter int V_VSYNC_E = 247
) (
    input  logic       CLK,
    input  logic       n_RES,
    input  logic       PCLK_EN,
    input  logic       REN,
    output logic [8:0] H_out,
    output logic [8:0] V_out,
    output logic       SYNC,
    output logic       BURST,
    output logic       n_PICTURE,
    output logic       HC,
    output logic       VC,
    output logic       VB,
    output logic       ODD
);

    localparam logic [8:0] LP_HT_M1 = 9'(H_TOTAL - 1);
    localparam logic [8:0] LP_HT_M2 = 9'(H_TOTAL - 2);
    localparam logic [8:0] LP_HT_M3 = 9'(H_TOTAL - 3);
    localparam logic [8:0] LP_HPIC  = 9'(H_PIC);
    localparam logic [8:0] LP_HSS   = 9'(H_SYNC_S);
    localparam logic [8:0] LP_HSE   = 9'(H_SYNC_E);
    localparam logic [8:0] LP_HBS   = 9'(H_BURST_S);
    localparam logic [8:0] LP_HBE   = 9'(H_BURST_E);
    localparam logic [8:0] LP_VT_M1 = 9'(V_TOTAL - 1);
    localparam logic [8:0] LP_VT_M2 = 9'(V_TOTAL - 2);
    localparam logic [8:0] LP_VPIC  = 9'(V_PIC);
    localparam logic [8:0] LP_VBS   = 9'(V_VB_S);
    localparam logic [8:0] LP_VSS   = 9'(V_VSYNC_S);
    localparam logic [8:0] LP_VSE   = 9'(V_VSYNC_E);

    localparam logic [2:0] ST_PIC    = 3'd0;
    localparam logic [2:0] ST_FPORCH = 3'd1;
    localparam logic [2:0] ST_HSYNC  = 3'd2;
    localparam logic [2:0] ST_BREEZE = 3'd3;
    localparam logic [2:0] ST_CBURST = 3'd4;
    localparam logic [2:0] ST_BPORCH = 3'd5;

    logic [8:0] r_h, r_v;
    logic [2:0] r_state;
    logic       r_odd, r_skip;
    logic       r_sync, r_burst, r_npic, r_hc, r_vc, r_vb;

    logic [8:0] w_h_nxt, w_v_nxt;
    logic [2:0] w_state_nxt;
    logic       w_eol, w_frame_end, w_skip_nxt, w_odd_nxt, w_vsync_line;

    always_comb begin
        // End of line. Out-of-range H values also count as end of line, so
        // an illegal value is forced back to 0 on the next tick.
        // r_skip can only be set on the last line of an odd frame.
        w_eol       = (r_h >= LP_HT_M1) || (r_skip && (r_h == LP_HT_M2));
        w_frame_end = w_eol && (r_v >= LP_VT_M1);

        w_h_nxt = w_eol ? 9'd0 : 9'(r_h + 9'd1);
        if (w_eol)
            w_v_nxt = (r_v >= LP_VT_M1) ? 9'd0 : 9'(r_v + 9'd1);
        else
            w_v_nxt = (r_v > LP_VT_M1) ? 9'd0 : r_v;

        w_odd_nxt = r_odd ^ w_frame_end;

        // REN is sampled once, three pixels before the nominal line end.
        // Later REN changes cannot shorten or lengthen the line.
        if (w_eol)
            w_skip_nxt = 1'b0;
        else if ((r_v == LP_VT_M1) && r_odd && (r_h == LP_HT_M3))
            w_skip_nxt = REN;
        else
            w_skip_nxt = r_skip;

        // Line-segment FSM: each state steps forward when H enters the
        // next range, and any line wrap returns the FSM to PIC.
        w_state_nxt = r_state;
        if (w_eol) begin
            w_state_nxt = ST_PIC;
        end else begin
            case (r_state)
                ST_PIC:    if (w_h_nxt == LP_HPIC) w_state_nxt = ST_FPORCH;
                ST_FPORCH: if (w_h_nxt == LP_HSS)  w_state_nxt = ST_HSYNC;
                ST_HSYNC:  if (w_h_nxt == LP_HSE)  w_state_nxt = ST_BREEZE;
                ST_BREEZE: if (w_h_nxt == LP_HBS)  w_state_nxt = ST_CBURST;
                ST_CBURST: if (w_h_nxt == LP_HBE)  w_state_nxt = ST_BPORCH;
                ST_BPORCH: w_state_nxt = ST_BPORCH;
                default:   w_state_nxt = ST_PIC;
            endcase
        end

        w_vsync_line = (w_v_nxt >= LP_VSS) && (w_v_nxt < LP_VSE);
    end

    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            r_h     <= 9'd0;
            r_v     <= 9'd0;
            r_state <= ST_PIC;
            r_odd   <= 1'b0;
            r_skip  <= 1'b0;
            r_sync  <= 1'b0;
            r_burst <= 1'b0;
            r_npic  <= 1'b0;
            r_hc    <= 1'b0;
            r_vc    <= 1'b0;
            r_vb    <= 1'b0;
        end else if (PCLK_EN) begin
            r_h     <= w_h_nxt;
            r_v     <= w_v_nxt;
            r_state <= w_state_nxt;
            r_odd   <= w_odd_nxt;
            r_skip  <= w_skip_nxt;
            // Vertical-sync lines invert the sync level.
            r_sync  <= (w_state_nxt == ST_HSYNC) ^ w_vsync_line;
            r_burst <= (w_state_nxt == ST_CBURST) && !w_vsync_line;
            r_npic  <= !((w_state_nxt == ST_PIC) && (w_v_nxt < LP_VPIC));
            r_hc    <= (w_h_nxt == LP_HT_M1) || (w_skip_nxt && (w_h_nxt == LP_HT_M2));
            r_vc    <= (w_v_nxt == LP_VT_M1);
            r_vb    <= (w_v_nxt >= LP_VBS) && (w_v_nxt <= LP_VT_M2);
        end
    end

    assign H_out     = r_h;
    assign V_out     = r_v;
    assign SYNC      = r_sync;
    assign BURST     = r_burst;
    assign n_PICTURE = r_npic;
    assign HC        = r_hc;
    assign VC        = r_vc;
    assign VB        = r_vb;
    assign ODD       = r_odd;

endmodule

// File: doc/video_timing_sequencer.md
# video_timing_sequencer

Scanline/frame sequencer for the composite video generator. It runs its own horizontal and vertical position counters, advancing once per pixel-clock enable. From those counters it drives the generator's SYNC, BURST and n_PICTURE control inputs, plus the HC/VC/VB frame-timing strobes used by the rest of the PPU. A per-line state machine orders the line segments, and an odd-frame line-shortening rule keeps colour-subcarrier phase alternating between frames.

## Interface
Parameters:
- H_TOTAL, 341: pixels per line (H counts 0..H_TOTAL-1).
- H_PIC, 256: visible pixels; H < H_PIC is picture.
- H_SYNC_S, 277: first H of horizontal sync.
- H_SYNC_E, 302: first H after horizontal sync.
- H_BURST_S, 306: first H of colour burst.
- H_BURST_E, 321: first H after colour burst.
- V_TOTAL, 262: lines per frame (V counts 0..V_TOTAL-1).
- V_PIC, 240: visible lines.
- V_VB_S, 241: first vblank line.
- V_VSYNC_S, 244: first vertical-sync line.
- V_VSYNC_E, 247: first line after vertical sync.

Ports:
- CLK, in, 1: master clock; all state on rising edge.
- n_RES, in, 1: asynchronous active-low reset.
- PCLK_EN, in, 1: pixel tick; state advances only on CLK edges with PCLK_EN=1.
- REN, in, 1: rendering enabled; gates odd-frame line shortening.
- H_out, out, 9: current pixel position.
- V_out, out, 9: current line.
- SYNC, out, 1: sync level request to the generator.
- BURST, out, 1: colour-burst request.
- n_PICTURE, out, 1: low while the pixel is visible picture.
- HC, out, 1: high during the last pixel of a line.
- VC, out, 1: high during the whole last line of a frame.
- VB, out, 1: high during vblank lines V_VB_S..V_TOTAL-2.
- ODD, out, 1: frame parity; toggles at each frame wrap.

## Operation
- Line FSM states: PIC (H<H_PIC), FPORCH (H_PIC..H_SYNC_S-1), HSYNC (H_SYNC_S..H_SYNC_E-1), BREEZE (H_SYNC_E..H_BURST_S-1), CBURST (H_BURST_S..H_BURST_E-1), BPORCH (H_BURST_E..end of line).
- Each state transition happens on the tick where H enters the next range. BPORCH → PIC happens on line wrap.
- The FSM state must always equal the range decoded from H_out. The bench checks this every cycle.
- H increments each tick. On the tick where HC=1, H becomes 0 and V increments.
- On the tick where HC=1 and VC=1, V becomes 0 and ODD toggles.
- Odd-frame skip: when V=V_TOTAL-1, ODD=1 and REN=1, the line is one pixel short. HC asserts at H=H_TOTAL-2, and the wrap happens from there.
  - REN is sampled on the tick at H=H_TOTAL-3 of that line. Later REN changes do not affect the current line.
- n_PICTURE = 0 only when state=PIC and V<V_PIC. Otherwise it is 1.
- SYNC:
  - On normal lines: 1 in HSYNC, 0 elsewhere.
  - On vertical-sync lines (V_VSYNC_S ≤ V < V_VSYNC_E), inverted: 0 in HSYNC, 1 elsewhere.
- BURST = 1 in CBURST on every line except vertical-sync lines.
- VB, VC and HC are decoded from the registered counters and the ODD/REN state. All outputs are registered, glitch-free and valid in the same cycle as the H_out/V_out they describe.
- Width rules: counters are 9-bit unsigned. Values ≥ H_TOTAL or ≥ V_TOTAL are unreachable. If an illegal value is ever present, the next tick forces it to 0.

## Timing
- Reset (n_RES=0, asynchronous, any time including mid-line):
  - H_out=0, V_out=0, ODD=0, FSM=PIC.
  - SYNC=0, BURST=0, n_PICTURE=0, HC=0, VC=0, VB=0.
- The first tick after reset release moves to H=1. A reset asserted mid-frame aborts the frame; there is no partial-line completion.
- Output latency: one CLK after the PCLK_EN edge that changes the counters. Outputs hold between ticks.
- PCLK_EN=0 freezes all state. PCLK_EN may be held at 1 continuously.
- Normal frame length is H_TOTAL*V_TOTAL = 89342 ticks. An odd frame with REN=1 is 89341 ticks.

## Test plan
- Reset, then 341 ticks with PCLK_EN=1 → H wraps 340→0 with HC=1 at H=340, and V_out=1.
  - Same run: n_PICTURE is low for H 0..255 on V=0; SYNC is high for H 277..301; BURST is high for H 306..320.
- Run to V=244 → on lines 244..246 SYNC is low only for H 277..301 and BURST stays 0.
  - On line 247 normal sync resumes.
- Full frames with REN=1 → the first frame is 89342 ticks with ODD=0. The second is 89341 ticks, with HC at H=339 on V=261. ODD toggles at each wrap.
- REN=0 on odd frame → line 261 stays 341 pixels.
  - REN rising at H=339 of that line → no shortening.
- PCLK_EN toggled every 4th CLK → state changes only on enabled edges, and the frame still takes 89342 ticks.
- n_RES pulsed low at V=100, H=150 → all outputs return to reset values immediately. Counting restarts from H=0, V=0 after release.
- VB high for V 241..260 and low on V=261. VC high for all of V=261.
